// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and its hazard/sequencing controller.
// The datapath side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       dmemREN;
  logic       dmemWEN;
  logic       idex_memToReg;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_usesRt;
  logic       branch_taken;
  logic       jump_id;
  logic       halt_id;
  logic       halt_mwb;

  logic       pc_en;
  logic       imemREN;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       mwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       mwb_flush;
  logic       halt;

  modport master (
    output ihit, dhit, dmemREN, dmemWEN, idex_memToReg, idex_rd, ifid_rs, ifid_rt,
           ifid_usesRt, branch_taken, jump_id, halt_id, halt_mwb,
    input  pc_en, imemREN, ifid_en, idex_en, exmem_en, mwb_en,
           ifid_flush, idex_flush, exmem_flush, mwb_flush, halt
  );

  modport slave (
    input  ihit, dhit, dmemREN, dmemWEN, idex_memToReg, idex_rd, ifid_rs, ifid_rt,
           ifid_usesRt, branch_taken, jump_id, halt_id, halt_mwb,
    output pc_en, imemREN, ifid_en, idex_en, exmem_en, mwb_en,
           ifid_flush, idex_flush, exmem_flush, mwb_flush, halt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for a 5-stage pipeline: latch enables/flushes, PC enable, fetch request,
// halt-drain sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTING, HALTED} state_t;

  state_t state;
  state_t next_state;
  logic   halt_q;
  logic   mem_stall;
  logic   load_use;
  logic   run_eval;
  logic   halt_entry;

  logic pc_en_c, imem_c;
  logic ifid_en_c, idex_en_c, exmem_en_c, mwb_en_c;
  logic ifid_fl_c, idex_fl_c, exmem_fl_c, mwb_fl_c;

  assign mem_stall = (bus.dmemREN | bus.dmemWEN) & ~bus.dhit;
  assign load_use  = bus.idex_memToReg & (bus.idex_rd != 5'd0) &
                     ((bus.idex_rd == bus.ifid_rs) |
                      (bus.ifid_usesRt & (bus.idex_rd == bus.ifid_rt)));

  // RUN rules apply in RUN and in the DWAIT release cycle (memory term masked there)
  assign run_eval   = (state == RUN) | ((state == DWAIT) & bus.dhit);
  assign halt_entry = bus.halt_mwb & (run_eval | (state == HALTING));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN, DWAIT: begin
        if (halt_entry) begin
          next_state = HALTED;
        end else if (state == RUN && mem_stall) begin
          next_state = DWAIT;
        end else if (run_eval) begin
          next_state = (bus.halt_id && !bus.branch_taken) ? HALTING : RUN;
        end
      end
      HALTING: begin
        if (halt_entry) next_state = HALTED;
      end
      default: next_state = state;
    endcase
  end

  always_comb begin
    pc_en_c    = 1'b0;
    imem_c     = 1'b0;
    ifid_en_c  = 1'b0;
    idex_en_c  = 1'b0;
    exmem_en_c = 1'b0;
    mwb_en_c   = 1'b0;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    exmem_fl_c = 1'b0;
    mwb_fl_c   = 1'b0;
    if (!RST) begin
      case (state)
        RUN, DWAIT: begin
          imem_c = 1'b1;
          if (run_eval && !(state == RUN && mem_stall)) begin
            pc_en_c    = 1'b1;
            ifid_en_c  = 1'b1;
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            mwb_en_c   = 1'b1;
            if (bus.branch_taken) begin
              ifid_fl_c = 1'b1;
              idex_fl_c = 1'b1;
            end else if (load_use) begin
              pc_en_c   = 1'b0;
              ifid_en_c = 1'b0;
              idex_fl_c = 1'b1;
            end else if (bus.jump_id) begin
              ifid_fl_c = 1'b1;
            end else if (!bus.ihit) begin
              pc_en_c   = 1'b0;
              ifid_fl_c = 1'b1;
            end
          end
        end
        HALTING: begin
          ifid_fl_c = 1'b1;
          if (!mem_stall) begin
            ifid_en_c  = 1'b1;
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            mwb_en_c   = 1'b1;
          end
        end
        default: ;
      endcase
      // The halt instruction has reached MEM/WB: squash everything behind it
      if (halt_entry) begin
        pc_en_c    = 1'b0;
        imem_c     = 1'b0;
        mwb_en_c   = 1'b0;
        idex_fl_c  = 1'b1;
        exmem_fl_c = 1'b1;
        mwb_fl_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      halt_q <= halt_q | (next_state == HALTED);
      if ((state == RUN || state == DWAIT) && !pc_en_c && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.imemREN     = imem_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.idex_en     = idex_en_c;
  assign bus.exmem_en    = exmem_en_c;
  assign bus.mwb_en      = mwb_en_c;
  assign bus.ifid_flush  = ifid_fl_c;
  assign bus.idex_flush  = idex_fl_c;
  assign bus.exmem_flush = exmem_fl_c;
  assign bus.mwb_flush   = mwb_fl_c;
  assign bus.halt        = halt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; control outputs are packed as
// {pc_en, imemREN, ifid_en, idex_en, exmem_en, mwb_en, ifid_fl, idex_fl, exmem_fl, mwb_fl}.
module tb_pipeline_hazard_ctrl;
  localparam int W = 4;

  localparam logic [9:0] V_ZERO    = 10'b0000000000;
  localparam logic [9:0] V_RUN     = 10'b1111110000;
  localparam logic [9:0] V_LDUSE   = 10'b0101110100;
  localparam logic [9:0] V_MSTALL  = 10'b0100000000;
  localparam logic [9:0] V_BRANCH  = 10'b1111111100;
  localparam logic [9:0] V_JUMP    = 10'b1111111000;
  localparam logic [9:0] V_IMISS   = 10'b0111111000;
  localparam logic [9:0] V_HALTING = 10'b0011111000;
  localparam logic [9:0] V_HFREEZE = 10'b0000001000;
  localparam logic [9:0] V_HENTRY  = 10'b0011101111;
  localparam logic [9:0] M_NOIFEN  = 10'b1101111111;

  logic CLK;
  logic RST;
  logic [W-1:0] stall_cnt;
  int assertCount;
  int failCount;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(.STALL_CNT_W(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [9:0] outVec();
    return {bus.pc_en, bus.imemREN, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.mwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mwb_flush};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ihitV, input logic dhitV, input logic memR,
                               input logic loadUse, input logic branch, input logic jump,
                               input logic haltId, input logic haltMwb);
    bus.ihit          = ihitV;
    bus.dhit          = dhitV;
    bus.dmemREN       = memR;
    bus.dmemWEN       = 1'b0;
    bus.idex_memToReg = loadUse;
    bus.idex_rd       = loadUse ? 5'd5 : 5'd0;
    bus.ifid_rs       = loadUse ? 5'd5 : 5'd0;
    bus.ifid_rt       = 5'd0;
    bus.ifid_usesRt   = 1'b0;
    bus.branch_taken  = branch;
    bus.jump_id       = jump;
    bus.halt_id       = haltId;
    bus.halt_mwb      = haltMwb;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    RST = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_outs", 32'(outVec()), 32'(V_ZERO));
    checkOutput("reset_cnt", 32'(stall_cnt), 0);
    checkOutput("reset_halt", 32'(bus.halt), 0);
    tick();
    RST = 1'b0;
    #1;
    checkOutput("run_default", 32'(outVec()), 32'(V_RUN));

    $display("[TB] load-use");
    doReset();
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("lduse_outs", 32'(outVec()), 32'(V_LDUSE));
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lduse_after", 32'(outVec()), 32'(V_RUN));
    checkOutput("lduse_cnt", 32'(stall_cnt), 1);
    bus.idex_memToReg = 1'b1;
    bus.idex_rd = 5'd0;
    bus.ifid_rs = 5'd0;
    #1;
    checkOutput("lduse_r0", 32'(outVec()), 32'(V_RUN));
    bus.idex_rd = 5'd7;
    bus.ifid_rt = 5'd7;
    #1;
    checkOutput("lduse_rt_unused", 32'(outVec()), 32'(V_RUN));
    bus.ifid_usesRt = 1'b1;
    #1;
    checkOutput("lduse_rt_used", 32'(outVec()), 32'(V_LDUSE));

    $display("[TB] dcache miss");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("dmiss_frozen", 32'(outVec()), 32'(V_MSTALL));
      tick();
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("dmiss_release", 32'(outVec()), 32'(V_RUN));
    tick();
    checkOutput("dmiss_cnt", 32'(stall_cnt), 3);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("dhit_same_cycle", 32'(outVec()), 32'(V_RUN));
    tick();
    checkOutput("dhit_cnt", 32'(stall_cnt), 3);

    $display("[TB] branch/jump/imiss");
    doReset();
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("branch_lduse", 32'(outVec() & M_NOIFEN), 32'(V_BRANCH & M_NOIFEN));
    tick();
    checkOutput("branch_cnt", 32'(stall_cnt), 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("jump_outs", 32'(outVec()), 32'(V_JUMP));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("imiss_outs", 32'(outVec()), 32'(V_IMISS));
    tick();
    checkOutput("imiss_cnt", 32'(stall_cnt), 1);

    $display("[TB] flushed halt");
    doReset();
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("halt_flushed", 32'(outVec()), 32'(V_BRANCH));
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_ignored", 32'(outVec()), 32'(V_RUN));

    $display("[TB] halt drain");
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("halt_id_cycle", 32'(outVec()), 32'(V_RUN));
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 1, 0, 0);
      checkOutput("halting_freeze", 32'(outVec()), 32'(V_HFREEZE));
      tick();
    end
    applyStimulus(1, 1, 1, 1, 0, 1, 0, 0);
    checkOutput("halting_advance", 32'(outVec()), 32'(V_HALTING));
    checkOutput("halting_nohalt", 32'(bus.halt), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("halt_entry", 32'(outVec()), 32'(V_HENTRY));
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("halted_outs", 32'(outVec()), 32'(V_ZERO));
      checkOutput("halted_flag", 32'(bus.halt), 1);
      tick();
    end
    checkOutput("halted_cnt", 32'(stall_cnt), 0);

    $display("[TB] saturation");
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) checkOutput("sat_14", 32'(stall_cnt), 14);
    end
    checkOutput("sat_hold", 32'(stall_cnt), 15);

    $display("[TB] async reset in DWAIT");
    doReset();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("dwait_outs", 32'(outVec()), 32'(V_MSTALL));
    checkOutput("dwait_cnt", 32'(stall_cnt), 1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_outs", 32'(outVec()), 32'(V_ZERO));
    checkOutput("arst_cnt", 32'(stall_cnt), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    #1;
    checkOutput("arst_release", 32'(outVec()), 32'(V_RUN));
    tick();
    checkOutput("arst_run", 32'(outVec()), 32'(V_RUN));
    checkOutput("arst_cnt_after", 32'(stall_cnt), 0);
    checkOutput("arst_halt", 32'(bus.halt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for one core's 5-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Produces per-latch enable/flush, PC enable and the instruction-fetch request.
- Inputs are cache hits, hazard fields from ID/EX and IF/ID, branch/jump resolution, and halt.
- Owns the halt-drain sequence and a saturating stall-cycle counter; one instance per core.

Parameters:
STALL_CNT_W, 16, width of stall_cnt performance counter.

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  asynchronous, active-high reset
ihit  in  1  icache returned instruction this cycle
dhit  in  1  dcache completed data access this cycle
dmemREN  in  1  EX/MEM latch holds a load
dmemWEN  in  1  EX/MEM latch holds a store
idex_memToReg  in  1  ID/EX latch holds a load
idex_rd  in  5  destination register of ID/EX instruction
ifid_rs  in  5  rs of IF/ID instruction
ifid_rt  in  5  rt of IF/ID instruction
ifid_usesRt  in  1  IF/ID instruction reads rt
branch_taken  in  1  branch resolved taken in EX
jump_id  in  1  J/JAL/JR decoded in ID
halt_id  in  1  HALT decoded in ID
halt_mwb  in  1  halt flag at MEM/WB output
pc_en  out  1  PC register load enable
imemREN  out  1  instruction fetch request
ifid_en, idex_en, exmem_en, mwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, mwb_flush  out  1 each  latch clears to bubble; flush wins over enable
halt  out  1  core halted, sticky until reset
stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, DWAIT, HALTING, HALTED, held in a state register. Reset state is RUN; halt=0; stall_cnt=0.
- Reset is asynchronous. While RST=1, all enables, flushes, pc_en and imemREN are 0. Reset mid-DWAIT or mid-HALTING aborts to RUN with no residual stall.
- Outputs are combinational from state and inputs; state, halt and stall_cnt are registered.
- mem_req = dmemREN | dmemWEN.
- Defaults in RUN: all latch enables=1, flushes=0, pc_en=1, imemREN=1.
- Priority, highest first:
  1. Memory stall: mem_req & !dhit. All enables=0 and pc_en=0; next state DWAIT. mem_req & dhit in the same cycle causes no stall.
  2. branch_taken: pc_en=1 (target load); ifid_flush=1, idex_flush=1. Overrides load-use, jump and ihit miss.
  3. Load-use: idex_memToReg & idex_rd!=0 & (idex_rd==ifid_rs | (ifid_usesRt & idex_rd==ifid_rt)). pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB advance. Naturally one cycle.
  4. jump_id: pc_en=1, ifid_flush=1.
  5. !ihit: pc_en=0, ifid_flush=1 (bubble into ID); downstream advances.
- DWAIT:
  - All enables and pc_en are 0 while !dhit.
  - On dhit: apply RUN rules for that cycle with the memory stall term masked; next state RUN.
- HALTING:
  - Entered from RUN when halt_id=1 and the cycle is not stalled by rule 1 or flushed by rule 2. A flushed halt_id is ignored.
  - Each cycle: pc_en=0, imemREN=0, ifid_flush=1.
  - ID/EX, EX/MEM and MEM/WB keep advancing, still subject to rule 1 (stay in HALTING, freeze).
  - Load-use and jump are ignored in HALTING.
- HALTED:
  - Entered when halt_mwb=1 in RUN or HALTING.
  - In the entry cycle: mwb_en=0; idex_flush, exmem_flush and mwb_flush=1; pc_en=0; imemREN=0.
  - In HALTED: all enables, pc_en and imemREN are 0; halt=1 from the first HALTED cycle; exit only via RST.
- stall_cnt:
  - Increments by 1 in every RUN or DWAIT cycle with pc_en=0.
  - Saturates at 2^STALL_CNT_W-1 with no wrap.
  - Frozen in HALTING and HALTED.

Test Plan:
- Load-use: idex_memToReg=1, idex_rd=5, ifid_rs=5, ihit=1 for one cycle. Response: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Next cycle all enables 1; stall_cnt=1.
- Dcache miss: dmemREN=1, dhit=0 for 3 cycles, then dhit=1. Response: all enables 0 for 3 cycles (state DWAIT); release cycle has all enables 1. stall_cnt=3.
- Branch plus load-use in the same cycle: branch_taken=1 with load-use match. Response: pc_en=1, ifid_flush=1, idex_flush=1, ifid_en irrelevant; stall_cnt unchanged.
- Halt drain: halt_id=1, then halt_mwb=1 three cycles later with a dmem miss of 2 cycles interleaved. Response: imemREN=0 from the cycle after halt_id; halt=1 the cycle after halt_mwb; enables stay 0 for 10 further cycles.
- Saturation with STALL_CNT_W=4: hold ihit=0 for 20 cycles. Response: stall_cnt reaches 15 and holds.
- Async reset mid-DWAIT: assert RST between edges while in DWAIT. Response: outputs drop to 0 immediately. After release, state is RUN, stall_cnt=0, halt=0, pc_en=1 with ihit=1.
